seq_detect_logger: RTL and testbench
====================================

Name: seq_detect_logger

Overview:
- Consumes the single-bit detection flag of the serial 1101 pattern detector.
- Converts each detection into one timestamped event, buffers events in a small FIFO and counts them.
- Host or downstream logic drains events over a valid/ready interface.
- Sits directly downstream of the pattern FSM; its det_in is driven by the FSM's registered detection output.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of each logged event.
- CNT_W, 16, width of the saturating event and drop counters.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  1 = timestamp runs and detections are logged; 0 = frozen, detections ignored
- clr  input  1  synchronous clear of counters, sticky flag and FIFO contents
- det_in  input  1  detection flag from the pattern detector, high for one or more cycles per detection
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready at a clock edge
- evt_ts  output  TS_W  timestamp of the FIFO head; 0 when empty
- evt_cnt  output  CNT_W  number of detections accepted into the FIFO, saturating
- drop_cnt  output  CNT_W  number of detections lost to a full FIFO, saturating
- overflow  output  1  sticky; set on the first drop, cleared only by clr or rst
- fifo_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst = 0 at a clock edge):
  - All registers are zero: det_d, ts, FIFO pointers and level, evt_cnt, drop_cnt, overflow.
  - Outputs after that edge: evt_valid = 0, evt_ts = 0, fifo_level = 0.
  - Reset mid-operation discards buffered events and produces no handshake.
- Edge detect:
  - det_d registers det_in every cycle, regardless of en.
  - rise = det_in & ~det_d & en.
  - A det_in held high for several cycles is one event. A low then high again is a new event.
- Timestamp:
  - ts increments by 1 each cycle while en = 1 and wraps from 2^TS_W-1 to 0.
  - An event captures the ts value present in the cycle that rise is high, before that edge's increment.
- Push: on rise with the FIFO not full, the event is written and evt_cnt increments.
- Drop: on rise with the FIFO full and no pop in the same cycle:
  - The event is discarded.
  - drop_cnt increments.
  - overflow is set.
- Pop: when evt_valid & evt_ready at a clock edge, the head is removed. The next entry appears after that edge.
- Handshake:
  - evt_valid and evt_ts are registered, driven directly from FIFO state.
  - evt_ts holds stable while evt_valid = 1 and evt_ready = 0.
- Latency: a det_in rise sampled at edge N into an empty FIFO gives evt_valid = 1 from edge N onward, i.e. one cycle after det_in rises.
- Simultaneous push and pop:
  - Both take effect and fifo_level is unchanged.
  - When full, the pop frees the slot, so the push is accepted, not dropped.
  - When empty, only the push takes effect; there is no fall-through.
- Saturation: evt_cnt and drop_cnt stop at 2^CNT_W-1 and do not wrap.
- clr:
  - Takes priority over push, pop and drop in the same cycle.
  - Empties the FIFO and zeroes evt_cnt, drop_cnt and overflow.
  - Does not reset ts or det_d.
  - A rise coinciding with clr is discarded and not counted.
- Priority within one cycle: rst > clr > (pop, push/drop).
- en = 0:
  - ts is frozen and no events are pushed or dropped.
  - Popping continues normally.

Decomposition:
- Shared package seq_det_pkg holds:
  - The default constants TS_W, CNT_W and DEPTH.
  - A typedef for the event record, holding a single ts field, so later fields can be added without port churn.
- One natural sub-module: evt_fifo.
  - Synchronous FIFO with depth DEPTH and a registered head.
  - Ports: push/pop/flush, full/empty/level.
- seq_detect_logger holds the edge detect, timestamp, counters and overflow logic.

Test Plan:
1. Reset then idle: rst low 2 cycles, en = 1, det_in = 0 for 20 cycles -> evt_valid = 0, evt_cnt = 0, fifo_level = 0, overflow = 0.
2. Single pulse: det_in high one cycle when ts = 5, evt_ready = 1 -> evt_valid high for exactly one cycle with evt_ts = 5, evt_cnt = 1.
3. Held level: det_in high 4 cycles starting at ts = 10 -> exactly one event, ts = 10, evt_cnt = 1.
4. Overflow with DEPTH = 4 and evt_ready = 0:
   - Stimulus: 6 separated pulses.
   - Response: fifo_level = 4, evt_cnt = 4, drop_cnt = 2, overflow = 1.
   - Then assert evt_ready: the first four timestamps drain in order and overflow stays 1.
5. Full with simultaneous pop and push: FIFO full, evt_ready = 1 in the same cycle as a pulse -> level stays 4, drop_cnt unchanged, new ts is last out.
6. clr and reset mid-stream:
   - clr coinciding with a pulse while level = 3 -> level 0, counters 0, overflow 0, no event logged.
   - Later, rst low while level = 2 -> evt_valid = 0 after that edge.

Source files
------------

// File: rtl/seq_detect_logger_pkg.sv
// Shared constants and event record for the 1101 detection logger.
//   DEF_TS_W  : default timestamp width
//   DEF_CNT_W : default saturating counter width
//   DEF_DEPTH : default event FIFO depth (power of two, >= 2)
//   evt_t     : logged event record; new fields can be added here without
//               touching module ports
package seq_det_pkg;

  localparam int unsigned DEF_TS_W  = 16;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_TS_W-1:0] ts;
  } evt_t;

endpackage

// File: rtl/seq_detect_logger_if.sv
// Control and event-drain bundle for seq_detect_logger.
//   master : drives en, clr, det_in, evt_ready; observes event and status
//   slave  : the logger side
interface seq_detect_logger_if
  import seq_det_pkg::*;
#(
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             en;
  logic             clr;
  logic             det_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [TS_W-1:0]  evt_ts;
  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output en, clr, det_in, evt_ready,
    input  evt_valid, evt_ts, evt_cnt, drop_cnt, overflow, fifo_level
  );

  modport slave (
    input  en, clr, det_in, evt_ready,
    output evt_valid, evt_ts, evt_cnt, drop_cnt, overflow, fifo_level
  );

endinterface

// File: rtl/seq_detect_logger_evt_fifo.sv
// Synchronous event FIFO with a registered head word.
//   clk, rst  : clock, synchronous active-low reset
//   push      : write data_in (accepted when not full, or full with a pop)
//   pop       : remove head (ignored when empty)
//   flush     : empty the FIFO; overrides push and pop
//   head      : registered head entry, zero when empty
//   valid     : registered, FIFO holds at least one entry
//   full_c    : combinational full flag
//   empty_c   : combinational empty flag
//   level     : registered occupancy 0..DEPTH
module evt_fifo
  import seq_det_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter type         T     = evt_t
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         data_in,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic                     valid,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_n;
  T                 head_q;
  T                 head_n;
  logic             pop_ok;
  logic             push_ok;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign empty_c = (level_q == '0);

  // A pop frees the slot a same-cycle push needs when full.
  assign pop_ok  = pop & ~empty_c;
  assign push_ok = push & (~full_c | pop_ok);

  // Next occupancy and next head word; the head is kept in its own register
  // so the consumer sees a registered payload.
  always_comb begin
    level_n = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    head_n  = head_q;
    if (flush) begin
      level_n = '0;
      head_n  = '0;
    end else if (pop_ok) begin
      if (level_q > LVL_W'(1)) begin
        head_n = mem[rd_ptr + PTR_W'(1)];
      end else if (push_ok) begin
        head_n = data_in;
      end else begin
        head_n = '0;
      end
    end else if (empty_c && push_ok) begin
      head_n = data_in;
    end
  end

  // Pointer, level and head state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
      valid   <= 1'b0;
    end else begin
      level_q <= level_n;
      head_q  <= head_n;
      valid   <= (level_n != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= data_in;
  end

  assign head  = head_q;
  assign level = level_q;

endmodule

// File: rtl/seq_detect_logger.sv
// Timestamped event logger for the 1101 pattern detector.
//   clk, rst        : clock, synchronous active-low reset
//   bus.en          : run timestamp and accept detections
//   bus.clr         : clear counters, overflow flag and buffered events
//   bus.det_in      : detection flag; each rising edge is one event
//   bus.evt_valid/evt_ready/evt_ts : drain handshake and head timestamp
//   bus.evt_cnt     : saturating count of accepted events
//   bus.drop_cnt    : saturating count of events lost to a full FIFO
//   bus.overflow    : sticky, set on first drop
//   bus.fifo_level  : current occupancy
module seq_detect_logger
  import seq_det_pkg::*;
#(
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEPTH = DEF_DEPTH
)(
  input  logic              clk,
  input  logic              rst,
  seq_detect_logger_if.slave bus
);

  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
  localparam int unsigned EVT_TS_W = $bits(evt_t);

  logic             det_d;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] evt_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             overflow_q;

  logic             rise_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             accept_c;
  logic             full_c;
  logic             empty_c;
  logic             valid;
  logic [LVL_W-1:0] level;
  evt_t             evt_in;
  evt_t             head;

  // One event per low-to-high transition while enabled; clr swallows it.
  assign rise_c   = bus.det_in & ~det_d & bus.en;
  assign pop_c    = ~empty_c & bus.evt_ready;
  assign push_c   = rise_c & ~bus.clr;
  assign drop_c   = push_c & full_c & ~pop_c;
  assign accept_c = push_c & ~drop_c;

  // Event captures the timestamp before this edge's increment.
  always_comb begin
    evt_in    = '0;
    evt_in.ts = EVT_TS_W'(ts);
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .data_in (evt_in),
    .pop     (pop_c),
    .flush   (bus.clr),
    .head    (head),
    .valid   (valid),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (level)
  );

  // Edge-detect history and free-running timestamp; clr leaves both alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      det_d <= 1'b0;
      ts    <= '0;
    end else begin
      det_d <= bus.det_in;
      if (bus.en) ts <= ts + TS_W'(1);
    end
  end

  // Saturating event/drop counters and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clr) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept_c && !(&evt_cnt_q)) evt_cnt_q  <= evt_cnt_q + CNT_W'(1);
      if (drop_c && !(&drop_cnt_q))  drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (drop_c)                    overflow_q <= 1'b1;
    end
  end

  assign bus.evt_valid  = valid;
  assign bus.evt_ts     = TS_W'(head.ts);
  assign bus.evt_cnt    = evt_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_seq_detect_logger.sv
// Self-checking bench for seq_detect_logger: directed scenarios followed by
// random traffic, compared against a queue-based behavioural model.
module tb_seq_detect_logger;
  import seq_det_pkg::*;

  localparam int unsigned TS_W  = DEF_TS_W;
  localparam int unsigned CNT_W = DEF_CNT_W;
  localparam int unsigned DEPTH = DEF_DEPTH;
  localparam int          TS_MOD  = 1 << TS_W;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  seq_detect_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

  seq_detect_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of pending timestamps plus plain counters.
  int q[$];
  int m_ts;
  int m_cnt;
  int m_drop;
  bit m_ovf;
  bit m_det_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit rise;
    if (!rst) begin
      q.delete();
      m_ts = 0; m_cnt = 0; m_drop = 0; m_ovf = 0; m_det_d = 0;
      return;
    end
    rise = bus.det_in && !m_det_d && bus.en;
    if (bus.clr) begin
      q.delete();
      m_cnt = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (q.size() > 0 && bus.evt_ready) void'(q.pop_front());
      if (rise) begin
        if (q.size() < DEPTH) begin
          q.push_back(m_ts);
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          if (m_drop < CNT_MAX) m_drop++;
          m_ovf = 1;
        end
      end
    end
    m_det_d = bus.det_in;
    if (bus.en) m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.evt_valid), 32'(q.size() != 0));
    chk({tag, ".ts"}, 32'(bus.evt_ts), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".level"}, 32'(bus.fifo_level), 32'(q.size()));
    chk({tag, ".cnt"}, 32'(bus.evt_cnt), 32'(m_cnt));
    chk({tag, ".drop"}, 32'(bus.drop_cnt), 32'(m_drop));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.clr = 1'b0; bus.det_in = 1'b0;
    step("rst");
    step("rst");
    rst = 1'b1;
  endtask

  task automatic pulse(input string tag);
    bus.det_in = 1'b1; step(tag);
    bus.det_in = 1'b0; step(tag);
  endtask

  int last_ts;

  initial begin
    rst = 1'b0; bus.en = 1'b1; bus.clr = 1'b0; bus.det_in = 1'b0; bus.evt_ready = 1'b0;
    #1;

    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) step("t1");
    chk("t1_valid", 32'(bus.evt_valid), 32'd0);
    chk("t1_cnt", 32'(bus.evt_cnt), 32'd0);

    // 2: single pulse at ts=5
    do_reset();
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 50 && m_ts != 5; i++) step("t2w");
    bus.det_in = 1'b1; step("t2");
    chk("t2_valid", 32'(bus.evt_valid), 32'd1);
    chk("t2_ts", 32'(bus.evt_ts), 32'd5);
    chk("t2_cnt", 32'(bus.evt_cnt), 32'd1);
    bus.det_in = 1'b0; step("t2");
    chk("t2_valid_off", 32'(bus.evt_valid), 32'd0);

    // 3: held level gives one event
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 50 && m_ts != 10; i++) step("t3w");
    bus.det_in = 1'b1;
    for (int i = 0; i < 4; i++) step("t3");
    bus.det_in = 1'b0; step("t3");
    chk("t3_cnt", 32'(bus.evt_cnt), 32'd1);
    chk("t3_ts", 32'(bus.evt_ts), 32'd10);
    chk("t3_level", 32'(bus.fifo_level), 32'd1);

    // 4: overflow with consumer stalled, then drain in order
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse("t4");
    chk("t4_level", 32'(bus.fifo_level), 32'd4);
    chk("t4_cnt", 32'(bus.evt_cnt), 32'd4);
    chk("t4_drop", 32'(bus.drop_cnt), 32'd2);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("t4d");
    chk("t4_ovf_hold", 32'(bus.overflow), 32'd1);
    chk("t4_empty", 32'(bus.fifo_level), 32'd0);

    // 5: full plus simultaneous pop and push
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse("t5");
    bus.evt_ready = 1'b1; bus.det_in = 1'b1;
    last_ts = m_ts;
    step("t5");
    chk("t5_level", 32'(bus.fifo_level), 32'd4);
    chk("t5_drop", 32'(bus.drop_cnt), 32'd0);
    bus.det_in = 1'b0;
    for (int i = 0; i < 3; i++) step("t5d");
    chk("t5_last", 32'(bus.evt_ts), 32'(last_ts));
    step("t5d");
    chk("t5_done", 32'(bus.evt_valid), 32'd0);

    // 6: clr coinciding with a pulse, then reset mid-stream
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse("t6");
    bus.det_in = 1'b1; bus.clr = 1'b1; step("t6c");
    chk("t6_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_cnt", 32'(bus.evt_cnt), 32'd0);
    chk("t6_ovf", 32'(bus.overflow), 32'd0);
    bus.clr = 1'b0; bus.det_in = 1'b0; step("t6");
    for (int i = 0; i < 2; i++) pulse("t6b");
    chk("t6_level2", 32'(bus.fifo_level), 32'd2);
    rst = 1'b0; step("t6r");
    chk("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
    rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.en        = ($urandom_range(7) != 0);
      bus.det_in    = ($urandom_range(2) == 0);
      bus.evt_ready = ($urandom_range(3) == 0);
      bus.clr       = ($urandom_range(60) == 0);
      rst           = ($urandom_range(250) != 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
